// File: rtl/clock_set_if.sv
// clock_set_if: bundles the button, tick, counter and display signals of clock_set_ctrl.
interface clock_set_if #(parameter int SEC_W = 17);
   logic             tick, btn_mode, btn_inc, btn_dec;
   logic [SEC_W-1:0] cur_sec, load_sec;
   logic             run_en, load;
   logic [1:0]       mode;
   logic [7:0]       seg_mask;
   modport master (output tick, btn_mode, btn_inc, btn_dec, cur_sec,
                   input run_en, load, load_sec, mode, seg_mask);
   modport slave (input tick, btn_mode, btn_inc, btn_dec, cur_sec,
                  output run_en, load, load_sec, mode, seg_mask);
endinterface

// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: run/set mode controller that freezes, edits and reloads the clock's seconds count.
// Defining CLOCK_SET_AUTOREPEAT_EN adds tick-paced auto-repeat of a held inc/dec button.
module clock_set_ctrl #(
   parameter int DAY_SEC = 86400,
   parameter int SEC_W   = 17
) (
   input logic        clk,
   input logic        rst,
   clock_set_if.slave ctl
);
   typedef enum logic [1:0] {RUN, SET_H, SET_M, SET_S} mode_e;
   localparam logic [SEC_W-1:0] DAY   = SEC_W'(DAY_SEC);
   localparam logic [SEC_W-1:0] S_HR  = SEC_W'(3600);
   localparam logic [SEC_W-1:0] S_MIN = SEC_W'(60);

   mode_e            mode_q, mode_d;
   logic [5:0]       hh_q, hh_d, mm_q, mm_d, ss_q, ss_d;
   logic             phase_q, phase_d, load_q, load_d;
   logic [SEC_W-1:0] load_sec_q, load_sec_d, cap;
   logic [2:0]       btn_q, ev_q;
   logic             set, up, dn;
   logic [7:0]       sel;
`ifdef CLOCK_SET_AUTOREPEAT_EN
   logic             held, fire;
   logic [1:0]       rpt_q, rpt_d;
`endif

   function automatic logic [5:0] wrap(input logic [5:0] v, input logic [5:0] top,
                                       input logic u, input logic d);
      return u ? (v == top ? 6'd0 : v + 6'd1) : d ? (v == 6'd0 ? top : v - 6'd1) : v;
   endfunction

   always_comb begin
      set = mode_q != RUN;
      up = set & ev_q[1] & ~ev_q[0] & ~ev_q[2];
      dn = set & ev_q[0] & ~ev_q[1] & ~ev_q[2];
`ifdef CLOCK_SET_AUTOREPEAT_EN
      held = set & (btn_q[1] ^ btn_q[0]) & ~ev_q[2];
      fire = held & ctl.tick & (rpt_q == 2'd2);
      rpt_d = !held ? 2'd0 : (ctl.tick && rpt_q != 2'd2) ? rpt_q + 2'd1 : rpt_q;
      up = up | (fire & btn_q[1]);
      dn = dn | (fire & btn_q[0]);
`endif
      cap = (ctl.cur_sec >= DAY) ? '0 : ctl.cur_sec;
      mode_d = ev_q[2] ? mode_e'(mode_q + 2'd1) : mode_q;
      hh_d = wrap(hh_q, 6'd23, up & (mode_q == SET_H), dn & (mode_q == SET_H));
      mm_d = wrap(mm_q, 6'd59, up & (mode_q == SET_M), dn & (mode_q == SET_M));
      ss_d = wrap(ss_q, 6'd59, up & (mode_q == SET_S), dn & (mode_q == SET_S));
      if (ev_q[2] && mode_q == RUN) begin
         hh_d = 6'(cap / S_HR);
         mm_d = 6'(cap % S_HR / S_MIN);
         ss_d = 6'(cap % S_MIN);
      end
      load_d = ev_q[2] & (mode_q == SET_S);
      load_sec_d = load_d ? SEC_W'(hh_q) * S_HR + SEC_W'(mm_q) * S_MIN + SEC_W'(ss_q) : load_sec_q;
      // any mode change or applied step restarts blinking in the visible phase
      phase_d = (ev_q[2] | up | dn) ? 1'b0 : (set & ctl.tick) ? ~phase_q : phase_q;
      sel = (mode_q == SET_H) ? 8'h30 : (mode_q == SET_M) ? 8'h0C : 8'h03;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         mode_q     <= RUN;
         hh_q       <= '0;
         mm_q       <= '0;
         ss_q       <= '0;
         phase_q    <= 1'b0;
         load_q     <= 1'b0;
         load_sec_q <= '0;
         btn_q      <= '0;
         ev_q       <= '0;
      end else begin
         mode_q     <= mode_d;
         hh_q       <= hh_d;
         mm_q       <= mm_d;
         ss_q       <= ss_d;
         phase_q    <= phase_d;
         load_q     <= load_d;
         load_sec_q <= load_sec_d;
         btn_q      <= {ctl.btn_mode, ctl.btn_inc, ctl.btn_dec};
         ev_q       <= {ctl.btn_mode, ctl.btn_inc, ctl.btn_dec} & ~btn_q;
      end
   end

`ifdef CLOCK_SET_AUTOREPEAT_EN
   always_ff @(posedge clk) begin
      if (!rst) rpt_q <= '0;
      else rpt_q <= rpt_d;
   end
`endif

   assign ctl.mode     = mode_q;
   assign ctl.run_en   = (mode_q == RUN) & ~load_q;
   assign ctl.load     = load_q;
   assign ctl.load_sec = load_sec_q;
   assign ctl.seg_mask = 8'h3F & ~((set & phase_q) ? sel : 8'h00);
endmodule
